regbank_write_arbiter: RTL

- Shares the write port of a small register bank (4 entries x 4 bits by default) between two requesters using a req/gnt/done handshake.
- Arbitration is round-robin when both requesters ask at once.
- Sits between two control sources (e.g. a serial loader and a control FSM) and the shared register storage.
- Provides a combinational read-back mux selected by `rd_sel`.

---
 rtl/regbank_write_arbiter_pkg.sv | 21 ++
 rtl/regbank_write_arbiter_reg_bank4.sv | 32 +++
 rtl/regbank_write_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/regbank_write_arbiter_pkg.sv
// Shared types and constants for the two-requester register-bank write arbiter.
package regbank_write_arbiter_pkg;

  localparam int unsigned DW_DEF = 4;
  localparam int unsigned AW_DEF = 2;

  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Requester index to one-hot handshake vector.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/regbank_write_arbiter_reg_bank4.sv
// 2**AW x DW register array: one synchronous write port, one combinational read mux.
module reg_bank4
  import regbank_write_arbiter_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] rd_sel,
  output logic [DW-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Reads during a write return the pre-write contents.
  assign rd_data = r_mem[rd_sel];

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin req/gnt/done arbiter sharing the write port of a small register bank.
module regbank_write_arbiter
  import regbank_write_arbiter_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [AW-1:0] wr_addr0,
  input  logic [DW-1:0] wr_data0,
  input  logic [AW-1:0] wr_addr1,
  input  logic [DW-1:0] wr_data1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic          busy,
  input  logic [AW-1:0] rd_sel,
  output logic [DW-1:0] rd_data
);

  state_t        r_state;
  logic          r_ptr;
  logic          r_win;
  logic [1:0]    r_gnt;
  logic [1:0]    r_done;
  logic          r_busy;
  logic [AW-1:0] r_cap_addr;
  logic [DW-1:0] r_cap_data;

  logic          w_any;
  logic          w_pick;
  logic          w_we;
  logic [AW-1:0] w_addr_win;
  logic [DW-1:0] w_data_win;

  // Single requester wins outright; a tie goes to the pointer.
  assign w_any      = req[REQ0] | req[REQ1];
  assign w_pick     = (req[REQ0] & req[REQ1]) ? r_ptr : req[REQ1];
  assign w_addr_win = r_win ? wr_addr1 : wr_addr0;
  assign w_data_win = r_win ? wr_data1 : wr_data0;
  assign w_we       = (r_state == WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= 1'b0;
      r_win      <= 1'b0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_busy     <= 1'b0;
      r_cap_addr <= '0;
      r_cap_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_win   <= w_pick;
            r_gnt   <= onehot2(w_pick);
            r_busy  <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          r_gnt <= '0;
          // Winner dropping req in its grant cycle aborts with no write.
          if (req[r_win]) begin
            r_cap_addr <= w_addr_win;
            r_cap_data <= w_data_win;
            r_done     <= onehot2(r_win);
            r_state    <= WRITE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        WRITE: begin
          r_done  <= '0;
          r_ptr   <= ~r_win;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign busy = r_busy;

  reg_bank4 #(
    .DW(DW),
    .AW(AW)
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (w_we),
    .waddr  (r_cap_addr),
    .wdata  (r_cap_data),
    .rd_sel (rd_sel),
    .rd_data(rd_data)
  );

endmodule
